// File: rtl/rv32i_types.sv
// Shared front-end types: sequencer state encoding and flush counter width.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } frontend_state_t;

  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frontend_flow_ctrl.sv
// Front-end sequencer: iqueue pop control, decode slot tracking, jump flush/redirect,
// per-cause stall counters and a sticky hang watchdog.
module frontend_flow_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WDOG_W       = 10,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iqueue_empty,
  output logic             iqueue_deq,
  input  logic             rename_accept,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             freelist_empty,
  input  logic             jump_commit,
  input  logic [31:0]      jump_target_pc,
  output logic             flush_frontend,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             dec_valid,
  output logic [CNT_W-1:0] stall_rob_cnt,
  output logic [CNT_W-1:0] stall_rs_cnt,
  output logic [CNT_W-1:0] stall_fl_cnt,
  output logic             hang
);

  frontend_state_t        state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_nx;
  logic                   blocked, stall_en;

  assign blocked  = dec_valid && !rename_accept;
  assign stall_en = (state_q == RUN) && blocked && !jump_commit;
  assign wdog_nx  = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (jump_commit) begin
      state_d = FLUSH;
      fcnt_d  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    end else begin
      case (state_q)
        FLUSH: begin
          if (fcnt_q == '0) state_d = REFILL;
          else              fcnt_d  = fcnt_q - FLUSH_CNT_W'(1);
        end
        REFILL:  if (!iqueue_empty) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Gated by rst so the decode register never loads while the block is held in reset.
  always_comb begin
    iqueue_deq = rst && (state_q == RUN) && !iqueue_empty && !blocked && !jump_commit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_frontend <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      dec_valid      <= 1'b0;
      wdog_q         <= '0;
      hang           <= 1'b0;
    end else begin
      flush_frontend <= (state_d == FLUSH);
      redirect_valid <= (state_q == FLUSH) && (fcnt_q == '0) && !jump_commit;
      if (jump_commit) redirect_pc <= jump_target_pc;
      if ((state_q == RUN) && !jump_commit) begin
        if (iqueue_deq)         dec_valid <= 1'b1;
        else if (rename_accept) dec_valid <= 1'b0;
      end else begin
        dec_valid <= 1'b0;
      end
      if (stall_en) begin
        wdog_q <= wdog_nx;
        if (wdog_nx == '1) hang <= 1'b1;
      end else begin
        wdog_q <= '0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_rob (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en && rob_full),
    .count (stall_rob_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_rs (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en && !rob_full && rs_full),
    .count (stall_rs_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_fl (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en && !rob_full && !rs_full && freelist_empty),
    .count (stall_fl_cnt)
  );

endmodule

// File: tb/tb_frontend_flow_ctrl.sv
// Bench for frontend_flow_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_frontend_flow_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned WW = 4;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int WD_MAX  = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst, iqueue_empty, iqueue_deq, rename_accept;
  logic          rob_full, rs_full, freelist_empty, jump_commit;
  logic [31:0]   jump_target_pc, redirect_pc;
  logic          flush_frontend, redirect_valid, dec_valid, hang;
  logic [CW-1:0] stall_rob_cnt, stall_rs_cnt, stall_fl_cnt;

  always #5 clk = ~clk;

  frontend_flow_ctrl #(.FLUSH_CYCLES(FC), .WDOG_W(WW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .iqueue_empty   (iqueue_empty),
    .iqueue_deq     (iqueue_deq),
    .rename_accept  (rename_accept),
    .rob_full       (rob_full),
    .rs_full        (rs_full),
    .freelist_empty (freelist_empty),
    .jump_commit    (jump_commit),
    .jump_target_pc (jump_target_pc),
    .flush_frontend (flush_frontend),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .stall_rob_cnt  (stall_rob_cnt),
    .stall_rs_cnt   (stall_rs_cnt),
    .stall_fl_cnt   (stall_fl_cnt),
    .hang           (hang)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flush expressed as "flush cycles still to show", refill as a wait-for-head flag.
  bit          model_on = 1'b0;
  int          m_flush_left = 0;
  bit          m_refill = 1'b0, m_dec = 1'b0, m_redir = 1'b0, m_hang = 1'b0;
  logic [31:0] m_pc = '0;
  int          m_rob = 0, m_rs = 0, m_fl = 0, m_wd = 0;

  function automatic bit exp_deq();
    return rst && (m_flush_left == 0) && !m_refill && !iqueue_empty &&
           !(m_dec && !rename_accept) && !jump_commit;
  endfunction

  always @(posedge clk) begin
    bit d, blk;
    d   = exp_deq();
    blk = m_dec && !rename_accept;
    if (!rst) begin
      m_flush_left = 0; m_refill = 0; m_dec = 0; m_redir = 0; m_hang = 0;
      m_pc = '0; m_rob = 0; m_rs = 0; m_fl = 0; m_wd = 0;
    end else if (jump_commit) begin
      m_flush_left = FC; m_refill = 0; m_dec = 0; m_redir = 0; m_pc = jump_target_pc; m_wd = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_redir  = (m_flush_left == 0);
      m_refill = (m_flush_left == 0);
      m_wd     = 0;
    end else if (m_refill) begin
      m_redir = 0;
      m_wd    = 0;
      if (!iqueue_empty) m_refill = 0;
    end else begin
      m_redir = 0;
      m_dec   = d ? 1'b1 : (rename_accept ? 1'b0 : m_dec);
      if (blk) begin
        if (rob_full)            m_rob = (m_rob < CNT_MAX) ? m_rob + 1 : m_rob;
        else if (rs_full)        m_rs  = (m_rs  < CNT_MAX) ? m_rs  + 1 : m_rs;
        else if (freelist_empty) m_fl  = (m_fl  < CNT_MAX) ? m_fl  + 1 : m_fl;
        m_wd = (m_wd < WD_MAX) ? m_wd + 1 : m_wd;
        if (m_wd == WD_MAX) m_hang = 1;
      end else begin
        m_wd = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("deq",     32'(iqueue_deq),     32'(exp_deq()));
      chk("flush",   32'(flush_frontend), 32'(m_flush_left > 0));
      chk("redir_v", 32'(redirect_valid), 32'(m_redir));
      chk("redir_pc", redirect_pc,        m_pc);
      chk("dec_v",   32'(dec_valid),      32'(m_dec));
      chk("rob_cnt", 32'(stall_rob_cnt),  32'(m_rob));
      chk("rs_cnt",  32'(stall_rs_cnt),   32'(m_rs));
      chk("fl_cnt",  32'(stall_fl_cnt),   32'(m_fl));
      chk("hang",    32'(hang),           32'(m_hang));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic set_in(input bit empty, input bit acc, input bit rob, input bit rs,
                        input bit fl, input bit jmp, input logic [31:0] tgt);
    iqueue_empty = empty; rename_accept = acc; rob_full = rob; rs_full = rs;
    freelist_empty = fl; jump_commit = jmp; jump_target_pc = tgt;
  endtask

  initial begin
    rst = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, '0);
    tick();
    model_on = 1'b1;
    tick();
    rst = 1'b1;
    half();
    chk("rst_deq", 32'(iqueue_deq), 32'd0);
    chk("rst_dec", 32'(dec_valid), 32'd0);
    chk("rst_flush", 32'(flush_frontend), 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_cnt", 32'(stall_rob_cnt) | 32'(stall_rs_cnt) | 32'(stall_fl_cnt), 32'd0);
    chk("rst_hang", 32'(hang), 32'd0);
    tick();

    // Back-to-back issue: four pops with rename accepting every cycle
    set_in(0, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      half();
      chk("flow_deq", 32'(iqueue_deq), 32'd1);
      if (i > 0) chk("flow_dec", 32'(dec_valid), 32'd1);
      tick();
    end
    // Slot held without accept and without any cause: no counter moves
    set_in(1, 0, 0, 0, 0, 0, '0);
    half();
    chk("hold_dec", 32'(dec_valid), 32'd1);
    tick();

    set_in(0, 0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      half();
      chk("bp_deq", 32'(iqueue_deq), 32'd0);
      tick();
    end
    set_in(0, 0, 0, 1, 1, 0, '0);
    half();
    chk("bp_rob5", 32'(stall_rob_cnt), 32'd5);
    chk("bp_rs0", 32'(stall_rs_cnt), 32'd0);
    tick();
    set_in(0, 0, 0, 0, 1, 0, '0);
    tick();
    set_in(0, 1, 0, 0, 0, 0, '0);
    half();
    chk("bp_resume", 32'(iqueue_deq), 32'd1);
    chk("bp_rs1", 32'(stall_rs_cnt), 32'd1);
    chk("bp_fl1", 32'(stall_fl_cnt), 32'd1);
    tick();

    // Single jump
    set_in(0, 1, 0, 0, 0, 1, 32'h6000_0040);
    half();
    chk("j_deq0", 32'(iqueue_deq), 32'd0);
    tick();
    set_in(0, 1, 0, 0, 0, 0, '0);
    for (int i = 1; i <= 4; i++) begin
      half();
      chk("j_flush", 32'(flush_frontend), 32'(i <= 2));
      chk("j_redir", 32'(redirect_valid), 32'(i == 3));
      chk("j_deq", 32'(iqueue_deq), 32'(i == 4));
      if (i == 3) chk("j_pc", redirect_pc, 32'h6000_0040);
      tick();
    end

    // Nested jump in the first flush cycle restarts the flush
    set_in(0, 1, 0, 0, 0, 1, 32'h6000_0080);
    tick();
    set_in(0, 1, 0, 0, 0, 1, 32'h6000_0100);
    for (int i = 1; i <= 5; i++) begin
      half();
      chk("nj_flush", 32'(flush_frontend), 32'(i <= 3));
      chk("nj_redir", 32'(redirect_valid), 32'(i == 4));
      chk("nj_deq", 32'(iqueue_deq), 32'(i == 5));
      if (i == 4) chk("nj_pc", redirect_pc, 32'h6000_0100);
      tick();
      set_in(0, 1, 0, 0, 0, 0, '0);
    end

    // Jump beats accept and a pending pop
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_1000);
    half();
    chk("pri_deq", 32'(iqueue_deq), 32'd0);
    tick();
    set_in(0, 1, 0, 0, 0, 0, '0);
    half();
    chk("pri_dec", 32'(dec_valid), 32'd0);
    tick();
    tick();
    tick();

    // Watchdog: one pop then 15 blocked cycles; fl counter saturates on the way
    set_in(0, 0, 0, 0, 0, 0, '0);
    half();
    chk("wd_pop", 32'(iqueue_deq), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 15; i++) begin
      half();
      chk("wd_nohang", 32'(hang), 32'd0);
      tick();
    end
    half();
    chk("wd_hang", 32'(hang), 32'd1);
    chk("fl_sat", 32'(stall_fl_cnt), 32'(CNT_MAX));
    tick();
    tick();
    set_in(0, 1, 0, 0, 0, 0, '0);
    tick();
    half();
    chk("hang_sticky", 32'(hang), 32'd1);
    tick();

    // Reset in the middle of a flush aborts it
    set_in(0, 1, 0, 0, 0, 1, 32'h0BAD_0000);
    tick();
    set_in(0, 1, 0, 0, 0, 0, '0);
    half();
    chk("rf_flush", 32'(flush_frontend), 32'd1);
    rst = 1'b0;
    tick();
    half();
    chk("rf_flush0", 32'(flush_frontend), 32'd0);
    chk("rf_pc0", redirect_pc, 32'd0);
    chk("rf_hang0", 32'(hang), 32'd0);
    chk("rf_deq0", 32'(iqueue_deq), 32'd0);
    tick();
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      half();
      chk("rf_noredir", 32'(redirect_valid), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frontend_flow_ctrl.md
# frontend_flow_ctrl

Front-end sequencer between the instruction queue, the decode stage register and rename/dispatch. It decides each cycle whether the iqueue head may be popped into decode. It tracks occupancy of the single decode slot under back-pressure from rename, and sequences the multi-cycle flush/redirect that follows a committed jump. It also keeps per-cause stall counters and a sticky hang detector for debug.

## Interface
- FLUSH_CYCLES, 2, cycles `flush_frontend` is held after a jump commit (1..15)
- WDOG_W, 10, width of hang watchdog; hang declared after 2^WDOG_W-1 consecutive blocked cycles
- CNT_W, 32, width of each stall performance counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (reset when 0 at a rising edge)
- iqueue_empty  input  1  iqueue has no valid head entry
- iqueue_deq  output  1  pop iqueue head this cycle; also the decode-register load enable (drives decode `iqueue_out_valid`)
- rename_accept  input  1  rename/dispatch consumes the decode slot this cycle
- rob_full, rs_full, freelist_empty  input  1 each  rename back-pressure causes
- jump_commit  input  1  ROB commits a mispredicted or taken jump
- jump_target_pc  input  32  correct PC for that jump
- flush_frontend  output  1  clear iqueue, fetch and decode register
- redirect_valid  output  1  one-cycle pulse: fetch restarts at `redirect_pc`
- redirect_pc  output  32  latched redirect target
- dec_valid  output  1  decode slot holds a live instruction
- stall_rob_cnt, stall_rs_cnt, stall_fl_cnt  output  CNT_W each  saturating stall counters
- hang  output  1  sticky watchdog flag

## Operation
- States: RUN, FLUSH, REFILL. Reset state is RUN.
- `blocked` = `dec_valid` && !`rename_accept`.
- RUN:
  - `iqueue_deq` = !`iqueue_empty` && !`blocked` && !`jump_commit` (combinational).
  - `dec_valid` next = `iqueue_deq` ? 1 : (`rename_accept` ? 0 : `dec_valid`).
- `jump_commit` in any state:
  - go to FLUSH and latch `jump_target_pc` into `redirect_pc`.
  - load flush counter with FLUSH_CYCLES-1.
  - clear `dec_valid`.
  - In the same cycle, `iqueue_deq` = 0 and the jump wins over any deq or accept.
- FLUSH:
  - `flush_frontend` = 1, `iqueue_deq` = 0, `dec_valid` = 0.
  - Counter decrements each cycle. At 0, go to REFILL with `redirect_valid` = 1 for that one transition cycle.
  - A new `jump_commit` during FLUSH reloads the counter and overwrites `redirect_pc`. Only one redirect pulse is issued, carrying the newest PC.
- REFILL: `iqueue_deq` = 0. Go to RUN on the first cycle `iqueue_empty` = 0; that head is popped in RUN on the next cycle.
- Stall counters increment only in RUN while `blocked`, with priority ROB > RS > freelist:
  - exactly one counter per blocked cycle;
  - no counter increments when no cause is asserted;
  - each counter saturates at all-ones.
- Watchdog:
  - counts consecutive `blocked` cycles in RUN;
  - clears on any cycle not blocked and on entry to FLUSH;
  - sets `hang` when it reaches 2^WDOG_W-1.
  - `hang` clears only on reset.

## Timing
- Reset values:
  - state RUN;
  - `iqueue_deq` 0, `flush_frontend` 0, `redirect_valid` 0, `redirect_pc` 0, `dec_valid` 0;
  - all counters 0, `hang` 0.
- `iqueue_deq` is combinational from state and inputs, so it can be asserted in the same cycle as `iqueue_empty`=0. The decode register loads on that edge.
- `flush_frontend` and `redirect_valid` are registered.
  - `flush_frontend` rises the cycle after `jump_commit` and stays high for FLUSH_CYCLES cycles.
  - `redirect_valid` pulses in the cycle after the last flush cycle.
- Minimum jump-to-first-new-pop: FLUSH_CYCLES + 2 cycles.
- Back-to-back issue: in steady RUN with `rename_accept` every cycle, throughput is one pop per cycle.
- Reset asserted mid-FLUSH aborts the flush: no redirect pulse, and all outputs go to reset values.

## Structure
- Add `frontend_state_t` (RUN/FLUSH/REFILL) to `rv32i_types`.
- One natural sub-module: `sat_counter` (CNT_W, increment enable, synchronous active-low reset), instantiated three times.
- FSM, slot tracking and watchdog stay in the top module.

## Test plan
- Flow: reset, then iqueue non-empty for 4 cycles with `rename_accept`=1 → `iqueue_deq`=1 for 4 consecutive cycles and `dec_valid`=1 throughout.
- Back-pressure:
  - `dec_valid`=1, `rob_full`=1 and `rs_full`=1, no accept for 5 cycles → `iqueue_deq`=0 for those cycles, `stall_rob_cnt`=5, `stall_rs_cnt`=0.
  - Then accept → pop resumes.
- Flush: `jump_commit` with target 0x6000_0040, FLUSH_CYCLES=2 → `flush_frontend` high cycles +1..+2, `redirect_valid` pulse at +3 with `redirect_pc`=0x6000_0040, first pop no earlier than +4.
- Nested jump:
  - second `jump_commit` (target 0x6000_0100) during FLUSH cycle 1 → counter restarts;
  - single `redirect_valid` pulse with 0x6000_0100.
- Priority: `jump_commit` in the same cycle as `rename_accept` and non-empty iqueue → `iqueue_deq`=0, `dec_valid`=0 next cycle.
- Watchdog and reset:
  - WDOG_W=4, blocked for 15 cycles → `hang`=1 and stays set.
  - `rst`=0 mid-FLUSH → all outputs 0 next cycle, no redirect.
